conv_batch_sequencer: RTL and testbench
=======================================

// Module: conv_batch_sequencer
// PURPOSE
//  Batch controller for the fix(8.8)->float16 converter datapath.
//  On start, walks COUNT operands in data memory, reads each 2-byte sign-magnitude word,
//  launches the converter, writes the 2-byte float result back, then raises done.
//  Sits between the testbench start/done handshake and the converter/data_mem ports.
// PARAMETERS
//  ADDR_W    8     data memory address width; all pointers wrap modulo 2**ADDR_W
//  TIMEOUT   64    max cycles to wait for cvt_done before aborting the batch
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-high master reset
//  start        in   1       pulse: begin batch (ignored unless IDLE or DONE)
//  src_base     in   ADDR_W  first operand address, sampled on accepted start
//  dst_base     in   ADDR_W  first result address, sampled on accepted start
//  count        in   8       number of operands, sampled on accepted start
//  done         out  1       batch finished; held until next accepted start
//  err          out  1       converter timeout; valid while done=1
//  DataAddress  out  ADDR_W  data_mem address
//  ReadMem      out  1       data_mem read enable (tied 1)
//  WriteMem     out  1       data_mem write enable, one cycle per byte
//  DataIn       out  8       write data to data_mem
//  DataOut      in   8       read data from data_mem, combinational on DataAddress
//  cvt_start    out  1       one-cycle launch pulse to converter
//  cvt_operand  out  16      {sign, int[14:0]} operand, stable from launch until cvt_done
//  cvt_done     in   1       converter result valid (sampled one cycle or more after cvt_start)
//  cvt_result   in   16      {sgn, exp[4:0], mant[9:0]}
// BEHAVIOUR
//  Reset (async): state=IDLE, done=0, err=0, WriteMem=0, cvt_start=0, DataAddress=0,
//   DataIn=0, cvt_operand=0, all pointers/counters=0. Reset mid-batch abandons it; no further writes.
//  Byte order: low byte at lower address; operand k at src_base+2k, result at dst_base+2k.
//  FSM per operand: RD_LO -> RD_HI -> LAUNCH -> WAIT -> WR_LO -> WR_HI -> NEXT.
//   RD_LO:  DataAddress=src, capture DataOut into operand[7:0].
//   RD_HI:  DataAddress=src+1, capture DataOut into operand[15:8].
//   LAUNCH: cvt_start=1 for exactly one cycle, clear watchdog.
//   WAIT:   hold until cvt_done=1; latch cvt_result. Watchdog reaching TIMEOUT -> err=1, go DONE.
//   WR_LO:  WriteMem=1, DataAddress=dst, DataIn=result[7:0].
//   WR_HI:  WriteMem=1, DataAddress=dst+1, DataIn=result[15:8].
//   NEXT:   src+=2, dst+=2, remaining-=1; remaining==0 -> DONE else RD_LO.
//  Latency per operand = 6 + W cycles (W = cycles in WAIT, >=1); batch = count*(6+W)+1 to done.
//  IDLE/DONE + start: sample bases/count, done<=0, err<=0 next edge; count==0 -> DONE
//   after one cycle with no memory access and no cvt_start.
//  start while busy (any other state): ignored, no effect on pointers or outputs.
//  start in same cycle done=1: accepted; done falls on the following edge.
//  Address wrap: src/dst increments wrap at 2**ADDR_W (0xFF+1 -> 0x00), including the +1 byte.
//  cvt_done outside WAIT: ignored. Overlapping src/dst regions: no hazard check; results
//   overwrite in address order.
//  WriteMem never asserted outside WR_LO/WR_HI; never two writes to one address per operand.
// STRUCTURE
//  conv_seq_pkg: state enum (IDLE,RD_LO,RD_HI,LAUNCH,WAIT,WR_LO,WR_HI,NEXT,DONE),
//   FLOAT_W=16, BYTE_W=8, operand/result field-width localparams.
//  Sub-module conv_seq_watchdog: clear/enable counter, asserts expire at TIMEOUT.
//  Remainder is one FSM plus pointer/count registers in this module.
// TESTING
//  1 operand 0x0180 (+1.5) at src=0x00, dst=0x02, converter model -> mem[2]=0x00, mem[3]=0x3E, done after 7+W cycles.
//  count=0 with start -> done=1 two edges later, WriteMem and cvt_start never asserted.
//  count=3, src=0xFC, dst=0x10, 0x8000/0x7FFF/0x0001 -> src wraps 0xFE->0x00; results
//   0x8000/0x57FF/0x1C00 written at 0x10..0x15.
//  cvt_done held low -> err=1, done=1 exactly TIMEOUT cycles into WAIT; no result bytes written.
//  Assert reset during WAIT of operand 2 of 4 -> all outputs at reset values same cycle; later
//   start runs a full clean batch.
//  Pulse start mid-batch, and again in the cycle done=1 -> first ignored, second restarts batch.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// Shared types and field widths for the fix(8.8)->float16 batch sequencer.
package conv_seq_pkg;

    localparam int unsigned FLOAT_W  = 16;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned OPER_W   = 16;
    localparam int unsigned INT_W    = 15;
    localparam int unsigned EXP_W    = 5;
    localparam int unsigned MANT_W   = 10;
    localparam int unsigned COUNT_W  = 8;

    typedef enum logic [3:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StLaunch,
        StWait,
        StWrLo,
        StWrHi,
        StNext,
        StDone
    } state_e;

endpackage

// File: rtl/conv_seq_watchdog.sv
// Cycle counter for converter completion; expire_o rises on the TIMEOUT-th enabled cycle.
module conv_seq_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expire_o) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expire_o = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/conv_batch_sequencer.sv
// Batch controller: reads sign-magnitude operands, drives the converter, writes float16 results.
module conv_batch_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   dst_base,
    input  logic [COUNT_W-1:0]  count,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   DataAddress,
    output logic                ReadMem,
    output logic                WriteMem,
    output logic [BYTE_W-1:0]   DataIn,
    input  logic [BYTE_W-1:0]   DataOut,
    output logic                cvt_start,
    output logic [OPER_W-1:0]   cvt_operand,
    input  logic                cvt_done,
    input  logic [FLOAT_W-1:0]  cvt_result
);

    state_e              state_q;
    logic [ADDR_W-1:0]   src_q, dst_q, addr_q;
    logic [COUNT_W-1:0]  rem_q;
    logic [OPER_W-1:0]   operand_q;
    logic [BYTE_W-1:0]   res_hi_q, data_in_q;
    logic                done_q, err_q, write_q, cvt_start_q;
    logic                wd_expire;

    conv_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_i    (reset),
        .clear_i  (state_q == StLaunch),
        .enable_i (state_q == StWait),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            src_q       <= '0;
            dst_q       <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            operand_q   <= '0;
            res_hi_q    <= '0;
            data_in_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            write_q     <= 1'b0;
            cvt_start_q <= 1'b0;
        end else begin
            write_q     <= 1'b0;
            cvt_start_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        src_q  <= src_base;
                        dst_q  <= dst_base;
                        rem_q  <= count;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                        // An empty batch passes through NEXT so done still rises one edge later.
                        if (count == '0) begin
                            state_q <= StNext;
                        end else begin
                            addr_q  <= src_base;
                            state_q <= StRdLo;
                        end
                    end
                end
                StRdLo: begin
                    operand_q[BYTE_W-1:0] <= DataOut;
                    addr_q                <= src_q + ADDR_W'(1);
                    state_q               <= StRdHi;
                end
                StRdHi: begin
                    operand_q[OPER_W-1:BYTE_W] <= DataOut;
                    cvt_start_q                <= 1'b1;
                    state_q                    <= StLaunch;
                end
                StLaunch: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (cvt_done) begin
                        res_hi_q  <= cvt_result[FLOAT_W-1:BYTE_W];
                        data_in_q <= cvt_result[BYTE_W-1:0];
                        addr_q    <= dst_q;
                        write_q   <= 1'b1;
                        state_q   <= StWrLo;
                    end else if (wd_expire) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StWrLo: begin
                    data_in_q <= res_hi_q;
                    addr_q    <= dst_q + ADDR_W'(1);
                    write_q   <= 1'b1;
                    state_q   <= StWrHi;
                end
                StWrHi: begin
                    state_q <= StNext;
                end
                StNext: begin
                    src_q <= src_q + ADDR_W'(2);
                    dst_q <= dst_q + ADDR_W'(2);
                    if (rem_q != '0) begin
                        rem_q <= rem_q - COUNT_W'(1);
                    end
                    if (rem_q <= COUNT_W'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        addr_q  <= src_q + ADDR_W'(2);
                        state_q <= StRdLo;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign done        = done_q;
    assign err         = err_q;
    assign DataAddress = addr_q;
    assign ReadMem     = 1'b1;
    assign WriteMem    = write_q;
    assign DataIn      = data_in_q;
    assign cvt_start   = cvt_start_q;
    assign cvt_operand = operand_q;

endmodule

// File: tb/tb_conv_batch_sequencer.sv
// Directed bench: byte memory and truncating fix(8.8)->float16 converter model around the sequencer.
module tb_conv_batch_sequencer;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  src_base = '0, dst_base = '0, count = '0;
    logic        done, err, ReadMem, WriteMem, cvt_start;
    logic [7:0]  DataAddress, DataIn, DataOut;
    logic [15:0] cvt_operand;
    logic        cvt_done = 1'b0;
    logic [15:0] cvt_result = '0;

    logic [7:0]  mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0, pl_data = '0;
    int          wr_cnt = 0, cs_cnt = 0;
    int          cvt_lat = 1;
    logic        cvt_hang = 1'b0;
    logic        cvt_busy = 1'b0;
    int          cvt_cnt = 0;

    int checks = 0;
    int errors = 0;

    conv_batch_sequencer #(
        .ADDR_W  (8),
        .TIMEOUT (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .count       (count),
        .done        (done),
        .err         (err),
        .DataAddress (DataAddress),
        .ReadMem     (ReadMem),
        .WriteMem    (WriteMem),
        .DataIn      (DataIn),
        .DataOut     (DataOut),
        .cvt_start   (cvt_start),
        .cvt_operand (cvt_operand),
        .cvt_done    (cvt_done),
        .cvt_result  (cvt_result)
    );

    always #5 clk = ~clk;

    assign DataOut = mem[DataAddress];

    always @(posedge clk) begin
        if (WriteMem) mem[DataAddress] <= DataIn;
        else if (pl_en) mem[pl_addr] <= pl_data;
        if (WriteMem) wr_cnt <= wr_cnt + 1;
        if (cvt_start) cs_cnt <= cs_cnt + 1;
    end

    function automatic logic [15:0] cvt_model(input logic [15:0] op);
        logic [14:0] mag;
        logic [9:0]  m;
        logic [4:0]  e;
        int          p;
        mag = op[14:0];
        if (mag == 15'd0) return {op[15], 15'd0};
        p = 0;
        for (int i = 0; i < 15; i++) if (mag[i]) p = i;
        e = 5'(p + 7);
        if (p >= 10) m = 10'(mag >> (p - 10));
        else         m = 10'(mag << (10 - p));
        return {op[15], e, m};
    endfunction

    // Converter: cvt_done pulses cvt_lat cycles after it sees cvt_start, unless hung.
    always @(posedge clk) begin
        cvt_done <= 1'b0;
        if (reset) begin
            cvt_busy <= 1'b0;
        end else if (cvt_start) begin
            cvt_busy   <= 1'b1;
            cvt_cnt    <= cvt_lat;
            cvt_result <= cvt_model(cvt_operand);
        end else if (cvt_busy && !cvt_hang) begin
            if (cvt_cnt <= 1) begin
                cvt_done <= 1'b1;
                cvt_busy <= 1'b0;
            end else begin
                cvt_cnt <= cvt_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic start_batch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] c);
        src_base = s; dst_base = d; count = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n, wr0, cs0;
    logic [7:0] exp8 [8];

    initial begin
        // Reset values
        tick(3);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_write", {15'd0, WriteMem}, 16'd0);
        chk("rst_cvt_start", {15'd0, cvt_start}, 16'd0);
        chk("rst_addr", {8'd0, DataAddress}, 16'd0);
        chk("rst_datain", {8'd0, DataIn}, 16'd0);
        chk("rst_operand", cvt_operand, 16'd0);
        chk("readmem_tied", {15'd0, ReadMem}, 16'd1);
        reset = 1'b0;
        tick(1);

        // Single operand +1.5, W = 2
        poke(8'h00, 8'h80); poke(8'h01, 8'h01); poke(8'h02, 8'hAA); poke(8'h03, 8'hAA);
        cvt_lat = 1;
        wr0 = wr_cnt; cs0 = cs_cnt;
        start_batch(8'h00, 8'h02, 8'd1);
        tick(7);
        chk("one_done_early", {15'd0, done}, 16'd0);
        tick(1);
        chk("one_done", {15'd0, done}, 16'd1);
        chk("one_err", {15'd0, err}, 16'd0);
        chk("one_lo", {8'd0, mem[8'h02]}, 16'h0000);
        chk("one_hi", {8'd0, mem[8'h03]}, 16'h003E);
        chk("one_operand", cvt_operand, 16'h0180);
        chk("one_writes", 16'(wr_cnt - wr0), 16'd2);
        chk("one_launches", 16'(cs_cnt - cs0), 16'd1);

        // Empty batch
        wr0 = wr_cnt; cs0 = cs_cnt;
        start_batch(8'h00, 8'h02, 8'd0);
        chk("zero_done_falls", {15'd0, done}, 16'd0);
        tick(1);
        chk("zero_done", {15'd0, done}, 16'd1);
        chk("zero_writes", 16'(wr_cnt - wr0), 16'd0);
        chk("zero_launches", 16'(cs_cnt - cs0), 16'd0);

        // Three operands, source wraps 0xFE -> 0x00, W = 3
        poke(8'hFC, 8'h00); poke(8'hFD, 8'h80);
        poke(8'hFE, 8'hFF); poke(8'hFF, 8'h7F);
        poke(8'h00, 8'h01); poke(8'h01, 8'h00);
        cvt_lat = 2;
        wr0 = wr_cnt;
        start_batch(8'hFC, 8'h10, 8'd3);
        wait_done(200, n);
        chk("wrap_cycles", 16'(n), 16'd27);
        exp8 = '{8'h00, 8'h80, 8'hFF, 8'h57, 8'h00, 8'h1C, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) chk($sformatf("wrap_mem%0d", i), {8'd0, mem[8'h10 + i]},
                                        {8'd0, exp8[i]});
        chk("wrap_writes", 16'(wr_cnt - wr0), 16'd6);

        // Converter never answers
        poke(8'h40, 8'h80); poke(8'h41, 8'h01); poke(8'h30, 8'h55); poke(8'h31, 8'h55);
        cvt_hang = 1'b1;
        wr0 = wr_cnt;
        start_batch(8'h40, 8'h30, 8'd1);
        tick(2 + T);
        chk("to_done_early", {15'd0, done}, 16'd0);
        tick(1);
        chk("to_done", {15'd0, done}, 16'd1);
        chk("to_err", {15'd0, err}, 16'd1);
        cvt_hang = 1'b0;
        tick(4);
        chk("to_late_done_ignored", {14'd0, done, err}, 16'd3);
        chk("to_no_writes", 16'(wr_cnt - wr0), 16'd0);
        chk("to_mem", {mem[8'h31], mem[8'h30]}, 16'h5555);

        // Reset during WAIT of operand 2 of 4, then a clean rerun, W = 4
        exp8 = '{8'h80, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h7F, 8'h00, 8'h80};
        for (int i = 0; i < 8; i++) poke(8'h50 + 8'(i), exp8[i]);
        for (int i = 0; i < 8; i++) poke(8'h60 + 8'(i), 8'hAA);
        cvt_lat = 3;
        wr0 = wr_cnt;
        start_batch(8'h50, 8'h60, 8'd4);
        tick(14);
        chk("mid_operand2", cvt_operand, 16'h0001);
        reset = 1'b1;
        #1;
        chk("mid_rst_outs", {done, err, WriteMem, cvt_start, DataAddress, DataIn[3:0]}, 16'd0);
        chk("mid_rst_datain", {8'd0, DataIn}, 16'd0);
        chk("mid_rst_operand", cvt_operand, 16'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("mid_writes", 16'(wr_cnt - wr0), 16'd2);
        chk("mid_op2_unwritten", {mem[8'h63], mem[8'h62]}, 16'hAAAA);
        start_batch(8'h50, 8'h60, 8'd4);
        wait_done(200, n);
        chk("rerun_cycles", 16'(n), 16'd40);
        exp8 = '{8'h00, 8'h3E, 8'h00, 8'h1C, 8'hFF, 8'h57, 8'h00, 8'h80};
        for (int i = 0; i < 8; i++) chk($sformatf("rerun_mem%0d", i), {8'd0, mem[8'h60 + i]},
                                        {8'd0, exp8[i]});

        // Start while busy is ignored; start in the done cycle restarts, W = 2
        poke(8'h80, 8'hAA); poke(8'h81, 8'hAA);
        cvt_lat = 1;
        start_batch(8'h50, 8'h70, 8'd1);
        tick(2);
        src_base = 8'h00; dst_base = 8'h80; count = 8'd2; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(50, n);
        chk("busy_start_cycles", 16'(n), 16'd5);
        chk("busy_result", {mem[8'h71], mem[8'h70]}, 16'h3E00);
        chk("busy_no_stray", {mem[8'h81], mem[8'h80]}, 16'hAAAA);
        start_batch(8'h54, 8'h90, 8'd1);
        chk("restart_done_falls", {15'd0, done}, 16'd0);
        wait_done(50, n);
        chk("restart_cycles", 16'(n), 16'd8);
        chk("restart_result", {mem[8'h91], mem[8'h90]}, 16'h57FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
